// File: rtl/alu_seq_if.sv
// Handshake and result bundle between the register-read stage, alu_seq and writeback.
// The issuing/consuming side uses master; the ALU uses slave.
interface alu_seq_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, negative, zero, carry_out, overflow, busy
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, negative, zero, carry_out, overflow, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/NZCV flags; SLL/SRL iterate one bit per cycle.
// SHIFT doubles as the one-cycle evaluate state (counter at zero) for every op.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset_n,
  alu_seq_if.slave   bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sh_c_q;
  logic [WIDTH-1:0] result_q, res_d;
  logic             n_q, z_q, c_q, v_q;
  logic             c_d, v_d;
  logic             accept, step, eval, sub, v_add;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;

  assign accept = bus.in_valid && bus.in_ready;
  assign step   = (state_q == S_SHIFT) && (cnt_q != '0);
  assign eval   = (state_q == S_SHIFT) && (cnt_q == '0);

  // Control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = bus.in_valid ? S_SHIFT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      cnt_d = (bus.op[2:1] == 2'b11) ? bus.b[SHW-1:0] : '0;
    end else if (step) begin
      cnt_d = cnt_q - SHW'(1);
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
    bus.out_valid = (state_q == S_DONE);
    bus.busy      = step;
    bus.result    = result_q;
    bus.negative  = n_q;
    bus.zero      = z_q;
    bus.carry_out = c_q;
    bus.overflow  = v_q;
  end

  // Captured operands; a_q also serves as the shift accumulator
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= bus.op;
      a_q    <= bus.a;
      b_q    <= bus.b;
      sh_c_q <= 1'b0;
    end else if (step) begin
      if (op_q == OP_SLL) begin
        sh_c_q <= a_q[WIDTH-1];
        a_q    <= {a_q[WIDTH-2:0], 1'b0};
      end else begin
        sh_c_q <= a_q[0];
        a_q    <= {1'b0, a_q[WIDTH-1:1]};
      end
    end
  end

  assign sub   = (op_q == OP_SUB) || (op_q == OP_SLT);
  assign bx    = sub ? ~b_q : b_q;
  assign sum   = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign v_add = (a_q[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

  always_comb begin
    res_d = sum[WIDTH-1:0];
    c_d   = sum[WIDTH];
    v_d   = v_add;
    case (op_q)
      OP_ADD, OP_SUB: begin
        res_d = sum[WIDTH-1:0];
      end
      OP_SLT: begin
        res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ v_add};
      end
      OP_XOR: begin
        res_d = a_q ^ b_q;
        c_d   = 1'b0;
        v_d   = 1'b0;
      end
      OP_AND: begin
        res_d = a_q & b_q;
        c_d   = 1'b0;
        v_d   = 1'b0;
      end
      OP_OR: begin
        res_d = a_q | b_q;
        c_d   = 1'b0;
        v_d   = 1'b0;
      end
      default: begin
        res_d = a_q;
        c_d   = sh_c_q;
        v_d   = 1'b0;
      end
    endcase
  end

  // Result and flags change only on the edge that enters DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (eval) begin
      result_q <= res_d;
      n_q      <= res_d[WIDTH-1];
      z_q      <= (res_d == '0);
      c_q      <= c_d;
      v_q      <= v_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: transaction-level reference model with per-cycle compare,
// directed literal cases at WIDTH=32 and WIDTH=8, stall, back-to-back and reset cases.
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  alu_seq #(.WIDTH(8))  dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result, {N,Z,C,V} and latency from plain integer arithmetic
  function automatic void model32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
    logic [63:0] us;
    longint      sv;
    logic        c, v;
    int          k;
    c = 1'b0; v = 1'b0; lat = 1; r = '0;
    k = int'(b[4:0]);
    case (op)
      3'b000: begin
        us = {32'd0, a} + {32'd0, b};
        r  = us[31:0];
        c  = us[32];
        sv = longint'($signed(a)) + longint'($signed(b));
        v  = (sv != longint'(int'(sv)));
      end
      3'b010, 3'b011: begin
        r  = a - b;
        c  = (a >= b);
        sv = longint'($signed(a)) - longint'($signed(b));
        v  = (sv != longint'(int'(sv)));
        if (op == 3'b011) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      end
      3'b001: r = a ^ b;
      3'b100: r = a & b;
      3'b101: r = a | b;
      3'b110: begin
        r   = a << k;
        c   = (k == 0) ? 1'b0 : a[32-k];
        lat = 1 + k;
      end
      default: begin
        r   = a >> k;
        c   = (k == 0) ? 1'b0 : a[k-1];
        lat = 1 + k;
      end
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  int          m_wait = 0;
  bit          m_hold = 1'b0;
  bit          m_acc  = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] exp_r = '0, p_r = '0;
  logic [3:0]  exp_f = '0, p_f = '0;

  function automatic bit m_ready();
    return (m_wait == 0 && !m_hold) || (m_hold && bus.out_ready);
  endfunction

  // Model: an accepted op produces its output lat cycles later and holds it until out_ready
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_wait = 0;
      m_hold = 1'b0;
      m_acc  = 1'b0;
    end else begin
      int  lat;
      bit  acc;
      acc   = bus.in_valid && m_ready();
      m_acc = acc;
      if (m_hold && bus.out_ready) begin
        m_hold = 1'b0;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_hold = 1'b1;
          exp_r  = p_r;
          exp_f  = p_f;
        end
      end
      if (acc) begin
        model32(bus.op, bus.a, bus.b, p_r, p_f, lat);
        m_wait = lat;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
      chk("out_valid", 64'(bus.out_valid), 64'(m_hold));
      chk("busy", 64'(bus.busy), 64'(m_wait >= 2));
      if (m_hold) begin
        chk("result", 64'(bus.result), 64'(exp_r));
        chk("flags", 64'({bus.negative, bus.zero, bus.carry_out, bus.overflow}), 64'(exp_f));
      end
    end
  end

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle32();
    int w = 0;
    bus.out_ready = 1'b1;
    while (!(bus.in_ready && !bus.out_valid) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk("idle_timeout", 64'(w), 64'(0));
  endtask

  task automatic run32(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input int elat);
    logic [31:0] mr;
    logic [3:0]  mf;
    int          ml, cyc, bcnt;
    model32(op, a, b, mr, mf, ml);
    chk({name, "_model_r"}, 64'(mr), 64'(er));
    chk({name, "_model_f"}, 64'(mf), 64'(ef));
    wait_idle32();
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    bcnt = bus.busy ? 1 : 0;
    cyc  = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.busy) bcnt++;
    end
    chk({name, "_result"}, 64'(bus.result), 64'(er));
    chk({name, "_nzcv"}, 64'({bus.negative, bus.zero, bus.carry_out, bus.overflow}), 64'(ef));
    chk({name, "_latency"}, 64'(cyc), 64'(elat));
    chk({name, "_busy_cycles"}, 64'(bcnt), 64'(elat - 1));
  endtask

  task automatic run8(input string name, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [3:0] ef);
    int cyc = 0;
    int w = 0;
    while (!bus8.in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    bus8.in_valid = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    while (!bus8.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, "_result"}, 64'(bus8.result), 64'(er));
    chk({name, "_nzcv"}, 64'({bus8.negative, bus8.zero, bus8.carry_out, bus8.overflow}), 64'(ef));
    chk({name, "_latency"}, 64'(cyc), 64'(1));
  endtask

  initial begin
    int w, seen;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_flags", 64'({bus.negative, bus.zero, bus.carry_out, bus.overflow}), 64'(0));
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk_en = 1'b1;

    run32("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 4'b1001, 1);
    run32("sub_neg", 3'b010, 32'h0,         32'h1,         32'hFFFF_FFFF, 4'b1000, 1);
    run32("slt_lt",  3'b011, 32'h0,         32'h1,         32'h1,         4'b0000, 1);
    run32("slt_ge",  3'b011, 32'h2,         32'h1,         32'h0,         4'b0110, 1);
    run32("add_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h0,         4'b0111, 1);
    run32("xor",     3'b001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 4'b1000, 1);
    run32("and",     3'b100, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000, 1);
    run32("or",      3'b101, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hFF0F_FF0F, 4'b1000, 1);
    run32("sll4",    3'b110, 32'h8000_0001, 32'h4,         32'h0000_0010, 4'b0000, 5);
    run32("srl1",    3'b111, 32'h3,         32'h1,         32'h1,         4'b0010, 2);
    run32("sll0",    3'b110, 32'h1234_5678, 32'h0,         32'h1234_5678, 4'b0000, 1);

    // Stall with out_ready low, then retire and issue on the same edge
    wait_idle32();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = 3'b000; bus.a = 32'd5; bus.b = 32'd6;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_result", 64'(bus.result), 64'(11));
      chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
      chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 3'b101; bus.a = 32'hF0; bus.b = 32'h0F;
    #1;
    chk("b2b_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_gap", 64'(bus.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("b2b_out_valid", 64'(bus.out_valid), 64'(1));
    chk("b2b_result", 64'(bus.result), 64'(32'hFF));

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (!bus.in_valid || m_acc) begin
        if ($urandom_range(0, 9) < 7) begin
          bus.in_valid = 1'b1;
          bus.op = 3'($urandom_range(0, 7));
          bus.a = rnd_opnd();
          bus.b = rnd_opnd();
        end else begin
          bus.in_valid = 1'b0;
          bus.a = $urandom;
          bus.b = $urandom;
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0;
    wait_idle32();

    // Reset in the middle of a long shift
    bus.in_valid = 1'b1; bus.op = 3'b110; bus.a = 32'hFFFF_FFFF; bus.b = 32'd20;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_shift_busy", 64'(bus.busy), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_result", 64'(bus.result), 64'(0));
    chk("arst_flags", 64'({bus.negative, bus.zero, bus.carry_out, bus.overflow}), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("no_stale_result", 64'(seen), 64'(0));

    run8("w8_add", 3'b000, 8'h7F, 8'h01, 8'h80, 4'b1001);
    run8("w8_sub", 3'b010, 8'h00, 8'h01, 8'hFF, 4'b1000);
    run8("w8_slt_lt", 3'b011, 8'h00, 8'h01, 8'h01, 4'b0000);
    run8("w8_slt_ge", 3'b011, 8'h02, 8'h01, 8'h00, 4'b0110);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 32-bit combinational ALU. It keeps the existing 2-bit opcode meanings as the low half of a 3-bit opcode. It adds AND, OR and logical shifts, registers the result and NZCV flags, and runs shifts iteratively at one bit per cycle. It sits between the register-read stage and writeback, behind a valid/ready handshake on both sides.

## Interface
- WIDTH, 32, datapath width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b.

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  block can accept an operation this cycle
- op  input  3  opcode: 000 ADD, 001 XOR, 010 SUB, 011 SLT, 100 AND, 101 OR, 110 SLL, 111 SRL
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; for shifts only b[SHW-1:0] is used
- out_valid  output  1  result and flags are valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  registered result
- negative, zero, carry_out, overflow  output  1 each  registered flags for the result
- busy  output  1  high while a shift is iterating

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- Accept: in_valid && in_ready. On accept, a, b and op are captured into internal registers; later changes on the inputs have no effect.
- Single-cycle ops (ADD, XOR, SUB, SLT, AND, OR):
  - Evaluated from the captured operands.
  - Block moves to DONE.
- Shifts (SLL, SRL):
  - Shift amount k = b[SHW-1:0].
  - k = 0: go directly to DONE with result = a.
  - k > 0: go to SHIFT. Each SHIFT cycle shifts by one bit and decrements the counter. Leave for DONE when the counter reaches 0.
  - Zeros are shifted in for both SLL and SRL.
- DONE: out_valid = 1. result and flags are held stable until out_ready.
- in_ready = (state == IDLE) || (state == DONE && out_ready). This allows back-to-back issue with no bubble.
- Arithmetic:
  - ADD: a + b, modulo 2^WIDTH.
  - SUB: a + ~b + 1.
  - carry_out is the carry out of bit WIDTH-1 of that addition. For SUB this means C = 1 when there is no borrow.
  - overflow is set when the operand signs (of a and of b or ~b as added) match and the result sign differs.
- SLT: result = {0…, N_sub ^ V_sub}, using the SUB computation. carry_out and overflow come from the SUB computation; negative and zero come from the SLT result.
- Logic ops: carry_out = 0, overflow = 0.
- Shifts:
  - carry_out = the last bit shifted out (0 when k = 0).
  - overflow = 0.
- All ops: negative = result[WIDTH-1]; zero = (result == 0).
- Reset:
  - State → IDLE.
  - result, all flags, out_valid and busy → 0.
  - in_ready = 1 once reset_n is high.
  - An in-flight shift is abandoned and produces no output.

## Timing
- Single-cycle op accepted at edge T: out_valid high after edge T+1.
- Shift by k accepted at edge T: out_valid high after edge T+1+k. busy is high for those k cycles.
- Result/flag registers update only on the edge that enters DONE.
- Back-to-back: if out_ready and in_valid are both high in DONE, the held result retires and the new op is captured on the same edge.
- Stall: with out_valid=1 and out_ready=0, the block holds indefinitely and in_ready stays 0.
- in_valid while in SHIFT, or while in DONE without out_ready, is ignored (in_ready=0). The source must hold its request.
- reset_n asserted at any point clears all outputs immediately, without waiting for clk.

## Test plan
- WIDTH=32, ADD a=0x7FFFFFFF, b=1, out_ready=1 → result 0x80000000 one cycle after accept; N=1, V=1, C=0, Z=0.
- SUB a=0, b=1 → result 0xFFFFFFFF, N=1, C=0, V=0. SLT with the same operands → result 1, N=0, Z=0. SLT a=2, b=1 → result 0, Z=1.
- ADD a=0x80000000, b=0x80000000 → result 0, Z=1, C=1, V=1. XOR a=0xF0F0F0F0, b=0x0F0F0F0F → 0xFFFFFFFF, N=1, C=V=0.
- SLL a=0x80000001, b=4 → busy for 4 cycles, out_valid at T+5, result 0x00000010, C=0. SRL a=0x3, b=1 → result 0x1, C=1. Shift with b=0 → result=a, latency 1.
- Hold out_ready=0 for 3 cycles after out_valid → result stable and in_ready=0. Raise out_ready together with a new in_valid → new op accepted on that edge, new result one cycle later.
- Assert reset_n=0 mid-SHIFT of a shift by 20 → out_valid, busy and flags read 0 before the next clk edge. After release, in_ready=1 and no stale result appears.
- Repeat the ADD/SUB/SLT cases at WIDTH=8: 0x7F+1 → 0x80, V=1.
